// File: rtl/comparator_serial_lsb.sv
// Bit-serial LSB-first unsigned magnitude comparator.
// A WIDTH-beat frame yields a greater/greater/equal result that is held under a valid/ready handshake.
module comparator_serial_lsb #(
  parameter int WIDTH = 8,
  localparam int CNTW = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic            bit_valid,
  output logic            bit_ready,
  input  logic            in1_bit,
  input  logic            in2_bit,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            in1_greater,
  output logic            in2_greater,
  output logic            equal,
  output logic [CNTW-1:0] beat_cnt
);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_DONE    = 1'b1;

  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(WIDTH - 1);

  logic [0:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            g1_q, g1_d;
  logic            g2_q, g2_d;
  logic            accept;

  // rst_n gates bit_ready so nothing looks acceptable while reset is held.
  assign bit_ready = rst_n & en & (state_q == S_COLLECT) & ~clr;
  assign accept    = bit_valid & bit_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    if (clr) begin
      state_d = S_COLLECT;
      cnt_d   = '0;
      g1_d    = 1'b0;
      g2_d    = 1'b0;
    end else if (state_q == S_DONE) begin
      if (res_ready) begin
        state_d = S_COLLECT;
        cnt_d   = '0;
        g1_d    = 1'b0;
        g2_d    = 1'b0;
      end
    end else if (accept) begin
      // A later (more significant) differing bit overrides any earlier decision.
      if (in1_bit != in2_bit) begin
        g1_d = in1_bit;
        g2_d = in2_bit;
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_BEAT) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
    end
  end

  assign res_valid   = (state_q == S_DONE);
  assign in1_greater = res_valid & g1_q;
  assign in2_greater = res_valid & g2_q;
  assign equal       = res_valid & ~g1_q & ~g2_q;
  assign beat_cnt    = cnt_q;

endmodule

// File: tb/tb_comparator_serial_lsb.sv
// Directed and randomized checks of comparator_serial_lsb against hand-computed values
// and a small value-based reference model.
module tb_comparator_serial_lsb;

  localparam int WIDTH = 8;
  localparam int CNTW  = $clog2(WIDTH + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            clr;
  logic            bit_valid;
  logic            bit_ready;
  logic            in1_bit;
  logic            in2_bit;
  logic            res_valid;
  logic            res_ready;
  logic            in1_greater;
  logic            in2_greater;
  logic            equal;
  logic [CNTW-1:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  comparator_serial_lsb #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .in1_bit     (in1_bit),
    .in2_bit     (in2_bit),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .in1_greater (in1_greater),
    .in2_greater (in2_greater),
    .equal       (equal),
    .beat_cnt    (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int from, input int to);
    for (int i = from; i < to; i++) begin
      in1_bit   = a[i];
      in2_bit   = b[i];
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic g1, input logic g2, input logic eq);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_g1"}, 32'(in1_greater), 32'(g1));
    chk({tag, "_g2"}, 32'(in2_greater), 32'(g2));
    chk({tag, "_eq"}, 32'(equal), 32'(eq));
    chk({tag, "_cnt"}, 32'(beat_cnt), 32'd8);
  endtask

  logic [7:0] ra, rb, ma, mb;
  int         mcnt;
  logic       mdone;
  int         frames;
  int         cycles;

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; bit_valid = 1'b1;
    in1_bit = 1'b0; in2_bit = 1'b0; res_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_flags", {29'd0, in1_greater, in2_greater, equal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bit_valid = 1'b0;
    #1;
    chk("post_rst_bit_ready", 32'(bit_ready), 32'd1);
    @(negedge clk);

    // 1: equal operands, back-to-back beats
    send_bits(8'hA5, 8'hA5, 0, 8);
    chk_result("t1", 1'b0, 1'b0, 1'b1);
    step();
    chk("t1_after_valid", 32'(res_valid), 32'd0);
    chk("t1_after_cnt", 32'(beat_cnt), 32'd0);
    chk("t1_after_ready", 32'(bit_ready), 32'd1);

    // 2: low-order difference overridden by MSB, then swapped
    send_bits(8'h80, 8'h7F, 0, 8);
    chk_result("t2a", 1'b1, 1'b0, 1'b0);
    step();
    send_bits(8'h7F, 8'h80, 0, 8);
    chk_result("t2b", 1'b0, 1'b1, 1'b0);
    step();

    // 3: result held while consumer stalls
    res_ready = 1'b0;
    send_bits(8'h01, 8'h00, 0, 8);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      #1;
      chk("t3_hold_g1", 32'(in1_greater), 32'd1);
      chk("t3_hold_bit_ready", 32'(bit_ready), 32'd0);
      step();
    end
    bit_valid = 1'b0;
    res_ready = 1'b1;
    step();
    chk("t3_release_valid", 32'(res_valid), 32'd0);
    chk("t3_release_cnt", 32'(beat_cnt), 32'd0);

    // 4: pause with en=0 after 3 beats
    send_bits(8'h3C, 8'h3D, 0, 3);
    en = 1'b0; bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_pause_ready", 32'(bit_ready), 32'd0);
      chk("t4_pause_cnt", 32'(beat_cnt), 32'd3);
      step();
    end
    en = 1'b1;
    send_bits(8'h3C, 8'h3D, 3, 8);
    chk_result("t4", 1'b0, 1'b1, 1'b0);
    step();

    // 5: clr drops an offered beat, then clears a pending result
    send_bits(8'h12, 8'h34, 0, 4);
    bit_valid = 1'b1; clr = 1'b1; in1_bit = 1'b1; in2_bit = 1'b0;
    #1;
    chk("t5_clr_ready", 32'(bit_ready), 32'd0);
    step();
    clr = 1'b0; bit_valid = 1'b0;
    chk("t5_clr_cnt", 32'(beat_cnt), 32'd0);
    res_ready = 1'b0;
    send_bits(8'hFF, 8'hFE, 0, 8);
    chk_result("t5", 1'b1, 1'b0, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr_res_valid", 32'(res_valid), 32'd0);
    chk("t5_clr_res_g1", 32'(in1_greater), 32'd0);
    chk("t5_clr_res_cnt", 32'(beat_cnt), 32'd0);
    res_ready = 1'b1;

    // 6: async reset mid-frame and with a result pending
    send_bits(8'h55, 8'hAA, 0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mid_cnt", 32'(beat_cnt), 32'd0);
    chk("t6_mid_ready", 32'(bit_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b0;
    send_bits(8'h01, 8'h00, 0, 8);
    chk("t6_pend_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(res_valid), 32'd0);
    chk("t6_rst_g1", 32'(in1_greater), 32'd0);
    chk("t6_rst_cnt", 32'(beat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random frames against a reference model
    ra = 8'($urandom); rb = 8'($urandom);
    ma = '0; mb = '0; mcnt = 0; mdone = 1'b0; frames = 0; cycles = 0;
    while (frames < 1000 && cycles < 60000) begin
      en        = ($urandom_range(0, 9) < 8);
      bit_valid = ($urandom_range(0, 9) < 7);
      res_ready = ($urandom_range(0, 9) < 6);
      in1_bit   = mdone ? 1'b0 : ra[mcnt];
      in2_bit   = mdone ? 1'b0 : rb[mcnt];
      #1;
      chk("rnd_bit_ready", 32'(bit_ready), 32'(!mdone && en));
      chk("rnd_res_valid", 32'(res_valid), 32'(mdone));
      chk("rnd_cnt", 32'(beat_cnt), 32'(mcnt));
      if (mdone) begin
        chk("rnd_g1", 32'(in1_greater), 32'(ma > mb));
        chk("rnd_g2", 32'(in2_greater), 32'(mb > ma));
        chk("rnd_eq", 32'(equal), 32'(ma == mb));
        if (res_ready) begin
          mdone = 1'b0; mcnt = 0; frames++;
          ra = 8'($urandom);
          rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
        end
      end else if (en && bit_valid) begin
        ma[mcnt] = in1_bit;
        mb[mcnt] = in2_bit;
        mcnt++;
        if (mcnt == WIDTH) mdone = 1'b1;
      end
      step();
      cycles++;
    end
    if (frames < 1000) begin
      checks++;
      errors++;
      $error("FAIL rnd_timeout observed=%0d expected=1000", frames);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
